i2c_target_responder: RTL and testbench
=======================================

Name: i2c_target_responder

Overview:
- Single-address I2C target (slave) that answers transactions started by the team's I2C controller on the shared open-drain SCL/SDA bus.
- Detects START, repeated START and STOP; matches a 7-bit address; ACKs; receives write bytes; returns read bytes.
- Sits behind the pad open-drain buffers. SCL/SDA arrive as synchronous samples; the block drives SDA only through an active-high pull-low enable.
- Clock stretching is not supported.

Parameters:
- SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (≥2).

Ports:
- p_clock  in  1  system clock; all logic on rising edge; SCL frequency ≤ p_clock/16.
- p_reset  in  1  synchronous, active-low reset.
- i2c_addr_i  in  7  own target address; sampled at each address phase.
- scl_i  in  1  bus SCL level from pad.
- sda_i  in  1  bus SDA level from pad.
- sda_oe_o  out  1  1 = pull SDA low; 0 = release.
- rx_data_o  out  8  last byte written by the controller; MSB first on the bus.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- tx_data_i  in  8  byte to return on a read; sampled on tx_load_o.
- tx_load_o  out  1  one-cycle pulse; tx_data_i is captured in the same cycle.
- addressed_o  out  1  high from address ACK until STOP, repeated START, or NACK.
- busy_o  out  1  high from START until STOP.

Behaviour:
- Reset (p_reset=0 at a p_clock edge): state IDLE; all outputs 0; synchronizer and edge flops set to 1 (idle bus). Reset mid-transfer releases SDA in the next cycle.
- Input path: SYNC_STAGES-flop synchronizer, then one registered copy for edge detection. An event is acted on SYNC_STAGES+1 cycles after the pad change.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognised in any state and take priority over the bit logic.
  - START or repeated START: clear bit counter, go to ADDR, busy_o=1, addressed_o=0, sda_oe_o=0.
  - STOP: go to IDLE, busy_o=0, addressed_o=0, sda_oe_o=0. A partial byte is discarded and rx_valid_o does not pulse.
- Sampling: SDA is sampled on each detected SCL rise. sda_oe_o changes only on a detected SCL fall (next cycle).
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR:
  - Shift in 8 bits: 7 address bits, then R/W.
  - On the fall after bit 8: if address == i2c_addr_i, set sda_oe_o=1, addressed_o=1, go to ADDR_ACK. Otherwise go to WAIT_STOP with SDA released.
- ADDR_ACK: on the next fall, release SDA if R/W=0 and go to WR_DATA. If R/W=1, pulse tx_load_o, load the shift register, drive sda_oe_o = ~tx_data_i[7], and go to RD_DATA.
- WR_DATA:
  - After the 8th rise, rx_data_o is updated and rx_valid_o pulses for one cycle.
  - On the following fall, sda_oe_o=1 (ACK) and go to WR_ACK.
  - Every byte is ACKed.
- WR_ACK: on the next fall, release SDA and go to WR_DATA with bit counter 0.
- RD_DATA: on each fall, shift left and drive the next bit. After the 8th bit's fall, release SDA and go to RD_ACK.
- RD_ACK: sample the controller ACK on the rise.
  - ACK (0): on the next fall, pulse tx_load_o, drive the new MSB, go to RD_DATA.
  - NACK (1): addressed_o=0, go to WAIT_STOP.
- WAIT_STOP: SDA released; only START or STOP leave this state.
- Bit counter is 4 bits and saturates; it is cleared at START and at each ACK fall.
- A STOP/START during RD_DATA releases SDA even when a 0 bit is being driven.

Test Plan:
- i2c_addr_i=7'b0000010; controller writes address 0x02 with W, then 0xA5 and 0x3C → ACK on each of the 3 ninth clocks; rx_valid_o pulses twice with rx_data_o=0xA5 then 0x3C; addressed_o high until STOP.
- i2c_addr_i=7'b0000010; controller addresses 7'b1100110 → sda_oe_o stays 0 throughout; no rx_valid_o or tx_load_o; NACK seen on bus; state WAIT_STOP until STOP.
- Read at 0x02 with tx_data_i=0x96, then 0x0F; controller ACKs byte 1 and NACKs byte 2 → bus carries 0x96, 0x0F; tx_load_o pulses exactly twice; SDA released after the NACK; addressed_o falls on the NACK.
- Write 0x11, then repeated START to 0x02 with R → rx_valid_o once; ACK on the new address; read phase begins with a tx_load_o pulse.
- STOP after 5 data bits of a write → no rx_valid_o; busy_o=0 and state IDLE SYNC_STAGES+1 cycles after the STOP edge.
- p_reset=0 while driving a 0 read bit → sda_oe_o=0 on the next p_clock edge and all outputs 0; a new START after reset is handled normally.

Source files
------------

// File: rtl/i2c_target_responder.sv
// Single-address I2C target: detects START/STOP, matches a 7-bit address,
// ACKs writes and returns read bytes through an active-high SDA pull-low enable.
module i2c_target_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       p_clock,
    input  logic       p_reset,
    input  logic [6:0] i2c_addr_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_load_o,
    output logic       addressed_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_now;
    logic                   sda_now;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_cond;
    logic                   stop_cond;

    state_t     state;
    state_t     state_n;
    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_n;
    logic [3:0] bit_cnt_inc;
    logic [7:0] shift_reg;
    logic [7:0] shift_n;
    logic       rw;
    logic       rw_n;
    logic       sda_oe_n;
    logic       addressed_n;
    logic       busy_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n;
    logic       tx_load;

    // Idle-bus reset value (both lines high) avoids a false START after reset.
    always_ff @(posedge p_clock) begin
        if (!p_reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl_now;
            sda_prev <= sda_now;
        end
    end

    assign scl_now    = scl_sync[SYNC_STAGES-1];
    assign sda_now    = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_now & ~scl_prev;
    assign scl_fall   = ~scl_now & scl_prev;
    assign start_cond = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_cond  = scl_now & scl_prev & ~sda_prev & sda_now;

    assign bit_cnt_inc = (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;

    always_ff @(posedge p_clock) begin
        if (!p_reset) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift_reg   <= 8'h00;
            rw          <= 1'b0;
            sda_oe_o    <= 1'b0;
            addressed_o <= 1'b0;
            busy_o      <= 1'b0;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift_reg   <= shift_n;
            rw          <= rw_n;
            sda_oe_o    <= sda_oe_n;
            addressed_o <= addressed_n;
            busy_o      <= busy_n;
            rx_data_o   <= rx_data_n;
            rx_valid_o  <= rx_valid_n;
        end
    end

    assign tx_load_o = tx_load & p_reset;

    // Bus conditions override the bit-level handling in every state.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        rw_n        = rw;
        sda_oe_n    = sda_oe_o;
        addressed_n = addressed_o;
        busy_n      = busy_o;
        rx_data_n   = rx_data_o;
        rx_valid_n  = 1'b0;
        tx_load     = 1'b0;

        if (start_cond) begin
            state_n     = ADDR;
            bit_cnt_n   = 4'd0;
            busy_n      = 1'b1;
            addressed_n = 1'b0;
            sda_oe_n    = 1'b0;
        end else if (stop_cond) begin
            state_n     = IDLE;
            bit_cnt_n   = 4'd0;
            busy_n      = 1'b0;
            addressed_n = 1'b0;
            sda_oe_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sda_oe_n = 1'b0;
                end
                ADDR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift_reg[6:0], sda_now};
                        bit_cnt_n = bit_cnt_inc;
                    end else if (scl_fall && bit_cnt >= 4'd8) begin
                        rw_n = shift_reg[0];
                        if (shift_reg[7:1] == i2c_addr_i) begin
                            sda_oe_n    = 1'b1;
                            addressed_n = 1'b1;
                            state_n     = ADDR_ACK;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = 4'd0;
                        if (rw) begin
                            tx_load  = 1'b1;
                            shift_n  = tx_data_i;
                            sda_oe_n = ~tx_data_i[7];
                            state_n  = RD_DATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift_reg[6:0], sda_now};
                        bit_cnt_n = bit_cnt_inc;
                        if (bit_cnt == 4'd7) begin
                            rx_data_n  = {shift_reg[6:0], sda_now};
                            rx_valid_n = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt >= 4'd8) begin
                        sda_oe_n = 1'b1;
                        state_n  = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = WR_DATA;
                    end
                end
                RD_DATA: begin
                    // The MSB was already driven on the load fall, so seven shifts follow.
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt_inc;
                    end else if (scl_fall) begin
                        if (bit_cnt >= 4'd8) begin
                            sda_oe_n = 1'b0;
                            state_n  = RD_ACK;
                        end else begin
                            shift_n  = {shift_reg[6:0], 1'b0};
                            sda_oe_n = ~shift_reg[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_now) begin
                        addressed_n = 1'b0;
                        sda_oe_n    = 1'b0;
                        state_n     = WAIT_STOP;
                    end else if (scl_fall) begin
                        tx_load   = 1'b1;
                        shift_n   = tx_data_i;
                        sda_oe_n  = ~tx_data_i[7];
                        bit_cnt_n = 4'd0;
                        state_n   = RD_DATA;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_n = 1'b0;
                end
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a simple open-drain controller model
// drives SCL/SDA and each scenario task checks the target's responses inline.
module tb_i2c_target_responder;

    localparam int Q = 10;
    localparam int SYNC = 2;

    logic       p_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic [6:0] i2c_addr = 7'b0000010;
    logic       scl_ctrl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       addressed;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         rx_count = 0;
    int         tx_count = 0;
    logic [7:0] rx_hist [0:7];
    logic       oe_seen = 1'b0;

    // Wired-AND bus: the target can only pull SDA low.
    assign sda_bus = sda_ctrl & ~sda_oe;

    i2c_target_responder #(.SYNC_STAGES(SYNC)) dut (
        .p_clock     (p_clock),
        .p_reset     (p_reset),
        .i2c_addr_i  (i2c_addr),
        .scl_i       (scl_ctrl),
        .sda_i       (sda_bus),
        .sda_oe_o    (sda_oe),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .tx_data_i   (tx_data),
        .tx_load_o   (tx_load),
        .addressed_o (addressed),
        .busy_o      (busy)
    );

    always #5 p_clock = ~p_clock;

    always @(negedge p_clock) begin
        if (rx_valid === 1'b1) begin
            if (rx_count < 8) rx_hist[rx_count] = rx_data;
            rx_count++;
        end
        if (tx_load === 1'b1) tx_count++;
        if (sda_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge p_clock);
    endtask

    task automatic clear_monitors();
        rx_count = 0;
        tx_count = 0;
        oe_seen  = 1'b0;
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1;
        tick(Q);
        scl_ctrl = 1'b1;
        tick(Q);
        sda_ctrl = 1'b0;
        tick(Q);
        scl_ctrl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0;
        tick(Q);
        scl_ctrl = 1'b1;
        tick(Q);
        sda_ctrl = 1'b1;
        tick(Q);
    endtask

    task automatic i2c_bit(input logic b, output logic seen);
        sda_ctrl = b;
        tick(Q);
        scl_ctrl = 1'b1;
        tick(Q);
        seen = sda_bus;
        tick(Q);
        scl_ctrl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_write(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic i2c_read(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(ack, s);
    endtask

    task automatic test_reset();
        p_reset = 1'b0;
        tick(4);
        checks++;
        if ({sda_oe, rx_valid, tx_load, addressed, busy} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected %b", {sda_oe, rx_valid, tx_load, addressed, busy}, 5'b00000);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_rx_data: got %h expected %h", rx_data, 8'h00);
        end
        p_reset = 1'b1;
        tick(4);
    endtask

    task automatic test_write();
        logic ack;
        clear_monitors();
        i2c_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_busy: got %b expected %b", busy, 1'b1);
        end
        i2c_write(8'h04, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_addr_ack: got %b expected %b", ack, 1'b0);
        end
        checks++;
        if (addressed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_addressed: got %b expected %b", addressed, 1'b1);
        end
        i2c_write(8'hA5, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_data1_ack: got %b expected %b", ack, 1'b0);
        end
        i2c_write(8'h3C, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_data2_ack: got %b expected %b", ack, 1'b0);
        end
        checks++;
        if (rx_count !== 2) begin
            errors++;
            $display("[TB] FAIL write_rx_count: got %0d expected %0d", rx_count, 2);
        end
        checks++;
        if (rx_hist[0] !== 8'hA5 || rx_hist[1] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL write_rx_bytes: got %h %h expected a5 3c", rx_hist[0], rx_hist[1]);
        end
        checks++;
        if (addressed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_addressed_hold: got %b expected %b", addressed, 1'b1);
        end
        i2c_stop();
        checks++;
        if ({addressed, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL write_after_stop: got %b expected %b", {addressed, busy}, 2'b00);
        end
        tick(Q);
    endtask

    task automatic test_wrong_addr();
        logic ack;
        clear_monitors();
        i2c_start();
        i2c_write(8'hCC, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrong_addr_nack: got %b expected %b", ack, 1'b1);
        end
        i2c_write(8'h55, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrong_addr_data_nack: got %b expected %b", ack, 1'b1);
        end
        checks++;
        if ({oe_seen, addressed, busy} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL wrong_addr_flags: got %b expected %b", {oe_seen, addressed, busy}, 3'b001);
        end
        checks++;
        if (rx_count !== 0 || tx_count !== 0) begin
            errors++;
            $display("[TB] FAIL wrong_addr_pulses: got rx=%0d tx=%0d expected 0 0", rx_count, tx_count);
        end
        i2c_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrong_addr_stop: got %b expected %b", busy, 1'b0);
        end
        tick(Q);
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        clear_monitors();
        tx_data = 8'h96;
        i2c_start();
        i2c_write(8'h05, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_addr_ack: got %b expected %b", ack, 1'b0);
        end
        tx_data = 8'h0F;
        i2c_read(1'b0, d);
        checks++;
        if (d !== 8'h96) begin
            errors++;
            $display("[TB] FAIL read_byte1: got %h expected %h", d, 8'h96);
        end
        checks++;
        if (addressed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_addressed: got %b expected %b", addressed, 1'b1);
        end
        tx_data = 8'hFF;
        i2c_read(1'b1, d);
        checks++;
        if (d !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL read_byte2: got %h expected %h", d, 8'h0F);
        end
        checks++;
        if ({addressed, sda_oe} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL read_after_nack: got %b expected %b", {addressed, sda_oe}, 2'b00);
        end
        checks++;
        if (tx_count !== 2) begin
            errors++;
            $display("[TB] FAIL read_tx_count: got %0d expected %0d", tx_count, 2);
        end
        i2c_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_stop: got %b expected %b", busy, 1'b0);
        end
        tick(Q);
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] d;
        clear_monitors();
        i2c_start();
        i2c_write(8'h04, ack);
        i2c_write(8'h11, ack);
        checks++;
        if (rx_count !== 1 || rx_hist[0] !== 8'h11) begin
            errors++;
            $display("[TB] FAIL rstart_rx: got count=%0d data=%h expected 1 11", rx_count, rx_hist[0]);
        end
        tx_data = 8'h5A;
        i2c_start();
        checks++;
        if ({addressed, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rstart_flags: got %b expected %b", {addressed, busy}, 2'b01);
        end
        i2c_write(8'h05, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstart_addr_ack: got %b expected %b", ack, 1'b0);
        end
        checks++;
        if (tx_count !== 1) begin
            errors++;
            $display("[TB] FAIL rstart_tx_load: got %0d expected %0d", tx_count, 1);
        end
        i2c_read(1'b1, d);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL rstart_read: got %h expected %h", d, 8'h5A);
        end
        i2c_stop();
        checks++;
        if (rx_count !== 1) begin
            errors++;
            $display("[TB] FAIL rstart_rx_total: got %0d expected %0d", rx_count, 1);
        end
        tick(Q);
    endtask

    task automatic test_stop_mid();
        logic ack;
        logic s;
        logic [4:0] bits;
        bits = 5'b10110;
        clear_monitors();
        i2c_start();
        i2c_write(8'h04, ack);
        for (int i = 4; i >= 0; i--) i2c_bit(bits[i], s);
        sda_ctrl = 1'b0;
        tick(Q);
        scl_ctrl = 1'b1;
        tick(Q);
        sda_ctrl = 1'b1;
        tick(SYNC);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_mid_early: got %b expected %b", busy, 1'b1);
        end
        tick(1);
        checks++;
        if ({busy, addressed} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stop_mid_latency: got %b expected %b", {busy, addressed}, 2'b00);
        end
        tick(Q);
        checks++;
        if (rx_count !== 0) begin
            errors++;
            $display("[TB] FAIL stop_mid_rx: got %0d expected %0d", rx_count, 0);
        end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        clear_monitors();
        tx_data = 8'h00;
        i2c_start();
        i2c_write(8'h05, ack);
        checks++;
        if (sda_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_driving: got %b expected %b", sda_oe, 1'b1);
        end
        p_reset = 1'b0;
        tick(1);
        checks++;
        if ({sda_oe, rx_valid, tx_load, addressed, busy} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs: got %b expected %b", {sda_oe, rx_valid, tx_load, addressed, busy}, 5'b00000);
        end
        tick(2);
        p_reset = 1'b1;
        tick(4);
        clear_monitors();
        i2c_start();
        i2c_write(8'h04, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_new_ack: got %b expected %b", ack, 1'b0);
        end
        i2c_write(8'h77, ack);
        checks++;
        if (rx_count !== 1 || rx_hist[0] !== 8'h77) begin
            errors++;
            $display("[TB] FAIL rst_mid_new_rx: got count=%0d data=%h expected 1 77", rx_count, rx_hist[0]);
        end
        i2c_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_stop: got %b expected %b", busy, 1'b0);
        end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_repeated_start();
        test_stop_mid();
        test_reset_mid_read();
        tick(Q);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
